// File: rtl/scnn_accum_drain_pkg.sv
// Shared sizing, FSM state encoding and ReLU helper for the accumulator drain stage.
package scnn_pkg;

  localparam int NUM_ENTRIES = 64;
  localparam int DATA_W      = 32;
  localparam int LANES       = 4;

  localparam int BEATS  = NUM_ENTRIES / LANES;
  localparam int IDX_W  = $clog2(BEATS);
  localparam int LANE_W = $clog2(LANES);
  localparam int ENT_W  = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [DATA_W-1:0] word_t;

  // Two's-complement clamp: anything with the sign bit set becomes zero.
  function automatic word_t relu(input word_t x);
    return x[DATA_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/scnn_accum_drain_if.sv
// Beat stream from the drain stage to the output-activation writer (valid/ready).
interface scnn_accum_drain_if;
  import scnn_pkg::*;

  logic                              out_valid;
  logic                              out_ready;
  logic [LANES-1:0][DATA_W-1:0]      out_data;
  logic [IDX_W-1:0]                  out_idx;
  logic                              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/scnn_accum_drain.sv
// Snapshots the accumulated partial-sum vector, optionally applies ReLU, streams it
// as LANES-wide beats and then pulses a clear back to the accumulation buffers.
module scnn_accum_drain
  import scnn_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                relu_en,
  input  logic [NUM_ENTRIES-1:0][DATA_W-1:0]  acc_in,
  output logic                                busy,
  output logic                                buf_clear,
  output logic                                done,
  scnn_accum_drain_if.master                  out_if
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  word_t            snap_q [NUM_ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
              snap_q[i] <= relu_en ? relu(acc_in[i]) : acc_in[i];
            end
            cnt_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          // valid_q is always high here, so out_ready alone marks a handshake.
          if (out_if.out_ready) begin
            if (cnt_q == LAST_IDX) begin
              cnt_q   <= '0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Lane k of beat n is entry n*LANES+k; data is forced to zero outside SEND.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [ENT_W-1:0] sel;
    assign sel                 = {cnt_q, LANE_W'(gi)};
    assign out_if.out_data[gi] = valid_q ? snap_q[sel] : '0;
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_idx   = cnt_q;
  assign out_if.out_last  = valid_q && (cnt_q == LAST_IDX);
  assign busy             = busy_q;
  assign done             = done_q;
  assign buf_clear        = done_q;

endmodule

// File: tb/tb_scnn_accum_drain.sv
// Scoreboard bench for scnn_accum_drain: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_scnn_accum_drain;
  import scnn_pkg::*;

  typedef struct {
    logic [IDX_W-1:0]             idx;
    logic [LANES-1:0][DATA_W-1:0] data;
    logic                         last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic relu_en = 1'b0;
  logic [NUM_ENTRIES-1:0][DATA_W-1:0] acc_in = '0;
  logic busy, buf_clear, done;

  scnn_accum_drain_if dif();

  scnn_accum_drain dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .relu_en   (relu_en),
    .acc_in    (acc_in),
    .busy      (busy),
    .buf_clear (buf_clear),
    .done      (done),
    .out_if    (dif)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail = 0;
  int    done_cnt = 0;
  int    hs_cnt = 0;
  bit    mon_en = 0;
  bit    exp_done_next = 0;
  bit    stall_prev = 0;
  logic [LANES-1:0][DATA_W-1:0] held_data;
  logic [IDX_W-1:0]             held_idx;
  beat_t sb_q[$];
  beat_t mon_e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_done_next) chk("done_pulse", 128'({done, buf_clear}), 128'(2'b11));
      else if (done || buf_clear) chk("spurious_done", 128'({done, buf_clear}), 128'(2'b00));
      if (done) done_cnt++;
      exp_done_next = 0;
      if (stall_prev) begin
        chk("stall_data", 128'(dif.out_data), 128'(held_data));
        chk("stall_idx", 128'(dif.out_idx), 128'(held_idx));
      end
      if (dif.out_valid && dif.out_ready) begin
        hs_cnt++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got idx %0d expected no beat", dif.out_idx);
        end else begin
          mon_e = sb_q.pop_front();
          $display("beat idx=%0d data=%h last=%0d", dif.out_idx, dif.out_data, dif.out_last);
          chk("beat_idx", 128'(dif.out_idx), 128'(mon_e.idx));
          chk("beat_data", 128'(dif.out_data), 128'(mon_e.data));
          chk("beat_last", 128'(dif.out_last), 128'(mon_e.last));
          if (mon_e.last) exp_done_next = 1;
        end
      end
      stall_prev = dif.out_valid && !dif.out_ready;
      held_data  = dif.out_data;
      held_idx   = dif.out_idx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beats derive from the vector the bench drives, clamped by hand when relu is requested.
  task automatic issue(input bit relu);
    beat_t e;
    logic [DATA_W-1:0] v;
    for (int b = 0; b < BEATS; b++) begin
      e.idx = IDX_W'(b);
      for (int l = 0; l < LANES; l++) begin
        v = acc_in[ENT_W'(b * LANES + l)];
        if (relu && v[DATA_W-1]) v = '0;
        e.data[l] = v;
      end
      e.last = (b == BEATS - 1);
      sb_q.push_back(e);
    end
    relu_en = relu;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    relu_en = 1'b0;
    chk("valid_after_start", 128'(dif.out_valid), 128'(1));
    chk("busy_after_start", 128'(busy), 128'(1));
    chk("idx_after_start", 128'(dif.out_idx), 128'(0));
  endtask

  task automatic wait_done(input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", tag, budget);
    end
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_valid"}, 128'(dif.out_valid), 128'(0));
    chk({tag, "_data"}, 128'(dif.out_data), 128'(0));
    chk({tag, "_idx"}, 128'(dif.out_idx), 128'(0));
    chk({tag, "_last"}, 128'(dif.out_last), 128'(0));
    chk({tag, "_clear"}, 128'(buf_clear), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
  endtask

  task automatic end_of_drain(input string tag, input int d0);
    chk({tag, "_sb_empty"}, 128'(sb_q.size()), 128'(0));
    chk({tag, "_done_count"}, 128'(done_cnt), 128'(d0 + 1));
    chk({tag, "_handshakes"}, 128'(hs_cnt), 128'(BEATS));
    chk({tag, "_idle_valid"}, 128'(dif.out_valid), 128'(0));
    chk({tag, "_idle_busy"}, 128'(busy), 128'(0));
  endtask

  initial begin
    int d0;
    bit drained;
    dif.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst_n  = 1'b1;
    mon_en = 1;
    tick();

    // Ascending vector, no ReLU, ready held high.
    for (int i = 0; i < NUM_ENTRIES; i++) acc_in[i] = DATA_W'(i);
    dif.out_ready = 1'b1;
    d0 = done_cnt; hs_cnt = 0;
    issue(1'b0);
    wait_done(40, "ascend");
    end_of_drain("ascend", d0);

    // Odd entries negative: clamped with ReLU, passed through without it.
    for (int i = 0; i < NUM_ENTRIES; i++) acc_in[i] = (i % 2 == 1) ? -DATA_W'(i) : DATA_W'(i);
    d0 = done_cnt; hs_cnt = 0;
    issue(1'b1);
    wait_done(40, "relu_on");
    end_of_drain("relu_on", d0);
    d0 = done_cnt; hs_cnt = 0;
    issue(1'b0);
    wait_done(40, "relu_off");
    end_of_drain("relu_off", d0);

    // Randomly stalled downstream.
    for (int i = 0; i < NUM_ENTRIES; i++) acc_in[i] = 32'hA500_0000 + DATA_W'(i * 7);
    d0 = done_cnt; hs_cnt = 0; drained = 0;
    dif.out_ready = 1'($urandom_range(0, 1));
    issue(1'b0);
    for (int k = 0; k < 400 && !drained; k++) begin
      @(negedge clk);
      if (done) drained = 1;
      @(posedge clk);
      #1;
      dif.out_ready = 1'($urandom_range(0, 1));
    end
    if (!drained) begin
      n_checks++; n_fail++;
      $display("FAIL random_ready_timeout: got no done expected done");
    end
    dif.out_ready = 1'b1;
    tick();
    end_of_drain("random_ready", d0);

    // acc_in change and second start during SEND must not disturb the drain.
    for (int i = 0; i < NUM_ENTRIES; i++) acc_in[i] = 32'h0000_1000 + DATA_W'(i);
    d0 = done_cnt; hs_cnt = 0;
    issue(1'b0);
    repeat (3) tick();
    acc_in = '1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_done(40, "restart");
    repeat (25) tick();
    end_of_drain("restart", d0);

    // Long stall on beat 0.
    for (int i = 0; i < NUM_ENTRIES; i++) acc_in[i] = DATA_W'(i + 64);
    dif.out_ready = 1'b0;
    d0 = done_cnt; hs_cnt = 0;
    issue(1'b0);
    repeat (100) tick();
    chk("stall100_valid", 128'(dif.out_valid), 128'(1));
    chk("stall100_idx", 128'(dif.out_idx), 128'(0));
    chk("stall100_busy", 128'(busy), 128'(1));
    chk("stall100_no_done", 128'(done_cnt), 128'(d0));
    dif.out_ready = 1'b1;
    wait_done(40, "stall100");
    end_of_drain("stall100", d0);

    // Reset asserted while beat 7 is presented.
    for (int i = 0; i < NUM_ENTRIES; i++) acc_in[i] = DATA_W'(i * 3);
    d0 = done_cnt;
    issue(1'b0);
    for (int k = 0; k < 30; k++) begin
      if (dif.out_idx == IDX_W'(7)) break;
      tick();
    end
    chk("reach_beat7", 128'(dif.out_idx), 128'(7));
    rst_n = 1'b0;
    sb_q.delete();
    stall_prev = 0;
    exp_done_next = 0;
    @(negedge clk);
    check_all_zero("abort");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("abort_no_done", 128'(done_cnt), 128'(d0));
    d0 = done_cnt; hs_cnt = 0;
    issue(1'b0);
    wait_done(40, "after_reset");
    end_of_drain("after_reset", d0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
